final_add_round_key: RTL and testbench

FINAL_ADD_ROUND_KEY -- requirements
Module: final_add_round_key

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_byte_buf.sv | 27 ++
 rtl/final_add_round_key.sv | 111 +++++++++++
 tb/tb_final_add_round_key.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-stream definitions: byte width, default block size and
// the final AddRoundKey controller state encoding.
package aes_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_OUT     = 2'd2
    } fsm_t;

    function automatic logic [BYTE_W-1:0] add_round_key(
        input logic [BYTE_W-1:0] s,
        input logic [BYTE_W-1:0] k
    );
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_byte_buf.sv
// NBYTES x 8 register file: indexed write on the clock, combinational read.
// Contents are never reset; the owner tracks validity with its own counter.
module aes_byte_buf
    import aes_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [NBYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/final_add_round_key.sv
// Final AES AddRoundKey: buffers one round-10 state block and one key block,
// then streams out state[i] ^ key[i] for i = 0..NBYTES-1.
module final_add_round_key
    import aes_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] state_din,
    input  logic              enable_state,
    input  logic [BYTE_W-1:0] key_din,
    input  logic              enable_key,
    output logic              round_complete,
    output logic [BYTE_W-1:0] dout,
    output logic              enable_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    fsm_t              fsm;
    logic [CNT_W-1:0]  s_cnt;
    logic [CNT_W-1:0]  k_cnt;
    logic [IDX_W-1:0]  o_idx;
    logic              s_full;
    logic              k_full;
    logic              cap_s;
    logic              cap_k;
    logic [BYTE_W-1:0] s_rd;
    logic [BYTE_W-1:0] k_rd;

    assign s_full = (s_cnt == FULL);
    assign k_full = (k_cnt == FULL);
    // Inputs are dropped while streaming out or once a stream's block is full.
    assign cap_s  = (fsm != ST_OUT) && enable_state && !s_full;
    assign cap_k  = (fsm != ST_OUT) && enable_key && !k_full;
    assign busy   = (fsm != ST_COLLECT);

    aes_byte_buf #(.NBYTES(NBYTES), .AW(IDX_W)) u_state_buf (
        .clk   (clk),
        .we    (cap_s),
        .waddr (s_cnt[IDX_W-1:0]),
        .wdata (state_din),
        .raddr (o_idx),
        .rdata (s_rd)
    );

    aes_byte_buf #(.NBYTES(NBYTES), .AW(IDX_W)) u_key_buf (
        .clk   (clk),
        .we    (cap_k),
        .waddr (k_cnt[IDX_W-1:0]),
        .wdata (key_din),
        .raddr (o_idx),
        .rdata (k_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= ST_COLLECT;
            s_cnt          <= '0;
            k_cnt          <= '0;
            o_idx          <= '0;
            dout           <= '0;
            enable_out     <= 1'b0;
            round_complete <= 1'b0;
        end else begin
            round_complete <= 1'b0;
            enable_out     <= 1'b0;
            if (cap_s) begin
                s_cnt <= s_cnt + CNT_W'(1);
                if (s_cnt == FULL - CNT_W'(1)) begin
                    round_complete <= 1'b1;
                end
            end
            if (cap_k) begin
                k_cnt <= k_cnt + CNT_W'(1);
            end
            unique case (fsm)
                ST_COLLECT, ST_WAIT: begin
                    // Decided on registered counts, so OUT starts one edge after the last capture.
                    if (s_full && k_full) begin
                        fsm   <= ST_OUT;
                        o_idx <= '0;
                    end else if (s_full || k_full) begin
                        fsm <= ST_WAIT;
                    end else begin
                        fsm <= ST_COLLECT;
                    end
                end
                ST_OUT: begin
                    dout       <= add_round_key(s_rd, k_rd);
                    enable_out <= 1'b1;
                    if (o_idx == LAST) begin
                        fsm   <= ST_COLLECT;
                        s_cnt <= '0;
                        k_cnt <= '0;
                        o_idx <= '0;
                    end else begin
                        o_idx <= o_idx + IDX_W'(1);
                    end
                end
                default: fsm <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_final_add_round_key.sv
// Directed bench for final_add_round_key: block-level XOR model with a
// per-cycle output scoreboard and literal ciphertext pins.
module tb_final_add_round_key;

    localparam logic [127:0] C1S = 128'he9317db5cb322c723d2e895faf090794;
    localparam logic [127:0] C1K = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C1O = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2S = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2O = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V3S = 128'h0123456789abcdeffedcba9876543210;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] state_din = 8'h00;
    logic [7:0] key_din = 8'h00;
    logic       enable_state = 1'b0;
    logic       enable_key = 1'b0;
    logic       round_complete;
    logic [7:0] dout;
    logic       enable_out;
    logic       busy;

    final_add_round_key #(.NBYTES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .state_din      (state_din),
        .enable_state   (enable_state),
        .key_din        (key_din),
        .enable_key     (enable_key),
        .round_complete (round_complete),
        .dout           (dout),
        .enable_out     (enable_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int blk_out = 0;
    int rc_cnt = 0;
    int rc_cyc = -1;
    int first_out_cyc = -1;
    int last_state_cyc = -1;
    int last_cap_cyc = -1;
    logic [127:0] got_blk = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid output byte must match the next expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (round_complete) begin
                rc_cnt++;
                rc_cyc = cyc;
            end
            if (enable_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got dout=%h required no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", blk_out), 128'(dout), 128'(e));
                    if (blk_out == 0) begin
                        first_out_cyc = cyc;
                        check("busy_in_out", 128'(busy), 128'(1));
                    end
                    if (blk_out < 16) got_blk[127-8*blk_out -: 8] = dout;
                    blk_out++;
                end
            end
        end
    end

    task automatic step(input logic es, input logic [7:0] sd, input logic ek, input logic [7:0] kd);
        enable_state = es;
        state_din = sd;
        enable_key = ek;
        key_din = kd;
        @(posedge clk);
        #1;
        enable_state = 1'b0;
        enable_key = 1'b0;
    endtask

    // mode 0: state then key; 1: key then state; 2: random interleave with gaps;
    // 3: as 0 plus 17th bytes and junk during output.
    task automatic send_block(input logic [127:0] st, input logic [127:0] ky, input int mode);
        int si = 0;
        int ki = 0;
        logic es, ek;
        logic [7:0] sd, kd;
        bit extra_done = 0;
        blk_out = 0;
        rc_cnt = 0;
        rc_cyc = -1;
        first_out_cyc = -1;
        last_state_cyc = -1;
        last_cap_cyc = -1;
        got_blk = '0;
        for (int i = 0; i < 16; i++) exp_q.push_back(byte_of(st, i) ^ byte_of(ky, i));
        while (si < 16 || ki < 16) begin
            es = 1'b0; ek = 1'b0; sd = 8'h00; kd = 8'h00;
            case (mode)
                1: if (ki < 16) ek = 1'b1; else es = 1'b1;
                2: begin
                    es = (si < 16) && ($urandom_range(0, 3) != 0);
                    ek = (ki < 16) && ($urandom_range(0, 3) != 0);
                end
                default: if (si < 16) es = 1'b1; else ek = 1'b1;
            endcase
            if (es && si < 16) sd = byte_of(st, si);
            if (ek && ki < 16) kd = byte_of(ky, ki);
            if (mode == 3 && si == 16 && !extra_done) begin
                es = 1'b1;
                sd = 8'hFF;
                extra_done = 1;
            end
            step(es, sd, ek, kd);
            if (es && si < 16) begin
                si++;
                if (si == 16) last_state_cyc = cyc;
                last_cap_cyc = cyc;
            end
            if (ek && ki < 16) begin
                ki++;
                last_cap_cyc = cyc;
            end
        end
        if (mode == 3) begin
            step(1'b0, 8'h00, 1'b1, 8'hAA);
            repeat (4) step(1'b1, 8'h55, 1'b1, 8'h55);
        end
    endtask

    task automatic finish_block(input string tag, input logic [127:0] lit);
        int n = 0;
        while (blk_out < 16 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (blk_out < 16) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d bytes required 16", tag, blk_out);
        end
        check({tag, "_block"}, got_blk, lit);
        check({tag, "_rc_count"}, 128'(rc_cnt), 128'(1));
        check({tag, "_rc_cycle"}, 128'(rc_cyc), 128'(last_state_cyc));
        check({tag, "_latency"}, 128'(first_out_cyc), 128'(last_cap_cyc + 2));
    endtask

    initial begin
        int n;
        #3 rst = 1'b1;
        #1;
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_enable_out", 128'(enable_out), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_round_complete", 128'(round_complete), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        send_block(C1S, C1K, 0);
        finish_block("c1", C1O);
        send_block(C1S, C1K, 1);
        finish_block("key_first", C1O);
        send_block(V2S, V2K, 2);
        finish_block("interleave", V2O);
        send_block(C1S, C1K, 3);
        finish_block("overflow", C1O);
        send_block(C1S, C1K, 0);
        finish_block("b2b_a", C1O);
        send_block(V3S, 128'h0, 2);
        finish_block("b2b_zero_key", V3S);

        send_block(C1S, C1K, 0);
        n = 0;
        while (blk_out < 6 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (blk_out < 6) begin
            n_checks++;
            $display("FAIL abort_timeout: got %0d bytes required 6", blk_out);
        end
        rst = 1'b1;
        #1;
        check("abort_enable_out", 128'(enable_out), 128'(0));
        check("abort_dout", 128'(dout), 128'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_enable_out_held", 128'(enable_out), 128'(0));
        rst = 1'b0;
        send_block(V2S, V2K, 2);
        finish_block("post_reset", V2O);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
